// File: rtl/ata_pio_sequencer.sv
// ATA/IDE PIO cycle sequencer: decodes the IDE window and times CS/IOR/IOW/DSACK1 for the CPU.
// Define ATA_TIMEOUT_EN to build the IORDY timeout that ends a stuck cycle with BERR.
module ata_pio_sequencer #(
  parameter logic [7:0] ATA_BASE    = 8'hDA,
  parameter int         SETUP_CYC   = 2,
  parameter int         STROBE_CYC  = 6,
  parameter int         HOLD_CYC    = 1,
  parameter int         RECOVER_CYC = 3,
  parameter int         TIMEOUT_CYC = 200
) (
  input  logic        CLKCPU,
  input  logic        RESET,
  input  logic        AS20,
  input  logic        RW20,
  input  logic [23:0] A,
  input  logic        IDEWAIT,
  output logic [1:0]  IDECS,
  output logic        IOR,
  output logic        IOW,
  output logic        DSACK1,
  output logic        BERR,
  output logic        ACCESS
);

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
  localparam logic [3:0] REC_LD    = (RECOVER_CYC > 0) ? 4'(RECOVER_CYC - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_WAIT, ST_ACK, ST_HOLD, ST_RECOVER
`ifdef ATA_TIMEOUT_EN
    , ST_BERRW
`endif
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        cs1_sel, cs1_nx;
  logic        rd_sel, rd_nx;
  logic        hit;
  logic        strobe_nx;
  logic [1:0]  cs_nx;
  logic        unused_bits;

  assign hit         = (A[23:16] == ATA_BASE) && (A[15:14] == 2'b00);
  assign ACCESS      = ~(hit & ~AS20);
  assign unused_bits = ^{A[13], A[11:0], 8'(TIMEOUT_CYC)};

`ifdef ATA_TIMEOUT_EN
  logic [7:0] tmo, tmo_nx, tmo_inc;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign tmo_inc = sat_inc8(tmo);
`else
  assign BERR = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cs1_nx   = cs1_sel;
    rd_nx    = rd_sel;
`ifdef ATA_TIMEOUT_EN
    tmo_nx   = tmo;
`endif
    case (state)
      ST_IDLE: if (!AS20 && hit) begin
        state_nx = ST_SETUP;
        cnt_nx   = SETUP_LD;
        cs1_nx   = A[12];
        rd_nx    = RW20;
      end
      ST_SETUP: begin
        if (AS20) begin
          state_nx = ST_HOLD;
          cnt_nx   = HOLD_LD;
        end else if (cnt == 4'd0) begin
          state_nx = ST_STROBE;
          cnt_nx   = STROBE_LD;
        end else cnt_nx = cnt - 4'd1;
      end
      ST_STROBE: begin
        if (AS20) begin
          state_nx = ST_HOLD;
          cnt_nx   = HOLD_LD;
        end else if (cnt == 4'd0) begin
          state_nx = IDEWAIT ? ST_ACK : ST_WAIT;
`ifdef ATA_TIMEOUT_EN
          tmo_nx   = 8'd0;
`endif
        end else cnt_nx = cnt - 4'd1;
      end
      ST_WAIT: begin
        if (AS20) begin
          state_nx = ST_HOLD;
          cnt_nx   = HOLD_LD;
        end else if (IDEWAIT) state_nx = ST_ACK;
`ifdef ATA_TIMEOUT_EN
        else if (tmo_inc == 8'(TIMEOUT_CYC)) state_nx = ST_BERRW;
        else tmo_nx = tmo_inc;
`endif
      end
      ST_ACK: if (AS20) begin
        state_nx = ST_HOLD;
        cnt_nx   = HOLD_LD;
      end
      ST_HOLD: begin
        if (cnt == 4'd0) begin
          if (RECOVER_CYC > 0) begin
            state_nx = ST_RECOVER;
            cnt_nx   = REC_LD;
          end else state_nx = ST_IDLE;
        end else cnt_nx = cnt - 4'd1;
      end
      ST_RECOVER: begin
        if (cnt == 4'd0) state_nx = ST_IDLE;
        else cnt_nx = cnt - 4'd1;
      end
`ifdef ATA_TIMEOUT_EN
      ST_BERRW: if (AS20) begin
        state_nx = ST_HOLD;
        cnt_nx   = HOLD_LD;
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it;
  // this keeps DSACK1 confined to ACK and CS stable around the strobe.
  always_comb begin
    strobe_nx = (state_nx == ST_STROBE) || (state_nx == ST_WAIT) || (state_nx == ST_ACK);
    cs_nx     = 2'b11;
    if (state_nx != ST_IDLE && state_nx != ST_RECOVER)
      cs_nx = cs1_nx ? 2'b01 : 2'b10;
  end

  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      cs1_sel <= 1'b0;
      rd_sel  <= 1'b0;
      IDECS   <= 2'b11;
      IOR     <= 1'b1;
      IOW     <= 1'b1;
      DSACK1  <= 1'b1;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      cs1_sel <= cs1_nx;
      rd_sel  <= rd_nx;
      IDECS   <= cs_nx;
      IOR     <= ~(strobe_nx & rd_nx);
      IOW     <= ~(strobe_nx & ~rd_nx);
      DSACK1  <= (state_nx != ST_ACK);
    end
  end

`ifdef ATA_TIMEOUT_EN
  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      tmo  <= 8'd0;
      BERR <= 1'b1;
    end else begin
      tmo  <= tmo_nx;
      BERR <= (state_nx != ST_BERRW);
    end
  end
`endif

endmodule

// File: tb/tb_ata_pio_sequencer.sv
// Directed bench for ata_pio_sequencer; expected output vectors are queued per cycle and checked at the falling edge.
module tb_ata_pio_sequencer;

  logic        clk = 1'b0;
  logic        rst, as20, rw20, idewait;
  logic [23:0] addr;
  logic [1:0]  idecs;
  logic        ior, iow, dsack1, berr, access;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [6:0] v;
  } exp_t;
  exp_t q[$];

  ata_pio_sequencer dut (
    .CLKCPU(clk), .RESET(rst), .AS20(as20), .RW20(rw20), .A(addr), .IDEWAIT(idewait),
    .IDECS(idecs), .IOR(ior), .IOW(iow), .DSACK1(dsack1), .BERR(berr), .ACCESS(access)
  );

  always #5 clk = ~clk;

  // {IDECS, IOR, IOW, DSACK1, BERR, ACCESS}
  function automatic logic [6:0] ov(input logic [1:0] cs, input logic ior_e, input logic iow_e,
                                    input logic dsack_e, input logic berr_e, input logic acc_e);
    return {cs, ior_e, iow_e, dsack_e, berr_e, acc_e};
  endfunction

  task automatic drain();
    exp_t       x;
    logic [6:0] obs;
    while (q.size() > 0) begin
      x   = q.pop_front();
      obs = {idecs, ior, iow, dsack1, berr, access};
      checks++;
      assert (obs === x.v) else begin
        errors++;
        $error("FAIL %s observed %b expected %b", x.tag, obs, x.v);
      end
    end
  endtask

  // Queue the expectation for the next clock edge, then check it at the falling edge.
  task automatic cyc(input string tag, input logic [6:0] e);
    q.push_back('{tag, e});
    @(negedge clk);
    drain();
  endtask

  task automatic idle_run(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, ov(2'b11, 1, 1, 1, 1, 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; as20 = 0; addr = 24'hDA0000; rw20 = 1; idewait = 1;
    cyc("rst0", ov(2'b11, 1, 1, 1, 1, 0));
    cyc("rst1", ov(2'b11, 1, 1, 1, 1, 0));
    rst = 0; as20 = 1;
    cyc("idle", ov(2'b11, 1, 1, 1, 1, 1));

    // Read on CS0, no wait: DSACK1 on edge 9, then hold and recovery
    as20 = 0; addr = 24'hDA0000; rw20 = 1; idewait = 1;
    for (int e = 1; e <= 10; e++) begin
      if (e <= 2)      cyc($sformatf("rd_setup_e%0d", e), ov(2'b10, 1, 1, 1, 1, 0));
      else if (e <= 8) cyc($sformatf("rd_strobe_e%0d", e), ov(2'b10, 0, 1, 1, 1, 0));
      else             cyc($sformatf("rd_ack_e%0d", e), ov(2'b10, 0, 1, 0, 1, 0));
    end
    as20 = 1;
    cyc("rd_hold", ov(2'b10, 1, 1, 1, 1, 1));
    idle_run("rd_recover", 4);

    // Write on CS1 with IORDY low for 10 strobe cycles
    as20 = 0; addr = 24'hDA1000; rw20 = 0; idewait = 0;
    for (int e = 1; e <= 12; e++) begin
      if (e <= 2) cyc($sformatf("wr_setup_e%0d", e), ov(2'b01, 1, 1, 1, 1, 0));
      else        cyc($sformatf("wr_strobe_e%0d", e), ov(2'b01, 1, 0, 1, 1, 0));
    end
    idewait = 1;
    cyc("wr_ack", ov(2'b01, 1, 0, 0, 1, 0));
    cyc("wr_ack2", ov(2'b01, 1, 0, 0, 1, 0));
    as20 = 1;
    cyc("wr_hold", ov(2'b01, 1, 1, 1, 1, 1));
    idle_run("wr_recover", 4);

    // Misses: wrong base, then A[15:14] nonzero
    as20 = 0; addr = 24'hDB0000; rw20 = 1;
    for (int i = 0; i < 3; i++) cyc("miss_base", ov(2'b11, 1, 1, 1, 1, 1));
    addr = 24'hDA4000;
    cyc("miss_a15", ov(2'b11, 1, 1, 1, 1, 1));
    as20 = 1;
    idle_run("miss_idle", 1);

    // Abort: AS20 negated during STROBE
    as20 = 0; addr = 24'hDA0000; rw20 = 1; idewait = 1;
    for (int e = 1; e <= 4; e++) begin
      if (e <= 2) cyc($sformatf("ab_setup_e%0d", e), ov(2'b10, 1, 1, 1, 1, 0));
      else        cyc($sformatf("ab_strobe_e%0d", e), ov(2'b10, 0, 1, 1, 1, 0));
    end
    as20 = 1;
    cyc("ab_hold", ov(2'b10, 1, 1, 1, 1, 1));
    idle_run("ab_recover", 4);

    // Back-to-back: second request waits out recovery and the idle cycle
    as20 = 0; addr = 24'hDA0000; rw20 = 1; idewait = 1;
    for (int e = 1; e <= 9; e++) begin
      if (e <= 2)      cyc("b1_setup", ov(2'b10, 1, 1, 1, 1, 0));
      else if (e <= 8) cyc("b1_strobe", ov(2'b10, 0, 1, 1, 1, 0));
      else             cyc("b1_ack", ov(2'b10, 0, 1, 0, 1, 0));
    end
    as20 = 1;
    cyc("b1_hold", ov(2'b10, 1, 1, 1, 1, 1));
    as20 = 0;
    for (int e = 11; e <= 23; e++) begin
      if (e <= 14)      cyc($sformatf("b2_pending_e%0d", e), ov(2'b11, 1, 1, 1, 1, 0));
      else if (e <= 16) cyc($sformatf("b2_setup_e%0d", e), ov(2'b10, 1, 1, 1, 1, 0));
      else if (e <= 22) cyc($sformatf("b2_strobe_e%0d", e), ov(2'b10, 0, 1, 1, 1, 0));
      else              cyc("b2_ack", ov(2'b10, 0, 1, 0, 1, 0));
    end
    as20 = 1;
    cyc("b2_hold", ov(2'b10, 1, 1, 1, 1, 1));
    idle_run("b2_recover", 4);

    // Reset in the middle of a strobe drops everything at once
    as20 = 0; addr = 24'hDA1000; rw20 = 0;
    for (int e = 1; e <= 4; e++) begin
      if (e <= 2) cyc("mr_setup", ov(2'b01, 1, 1, 1, 1, 0));
      else        cyc("mr_strobe", ov(2'b01, 1, 0, 1, 1, 0));
    end
    rst = 1;
    cyc("mr_reset", ov(2'b11, 1, 1, 1, 1, 0));
    rst = 0; as20 = 1;
    idle_run("mr_idle", 2);

    // IORDY stuck low
    as20 = 0; addr = 24'hDA0000; rw20 = 1; idewait = 0;
    for (int e = 1; e <= 209; e++) begin
      if (e <= 2)        cyc("to_setup", ov(2'b10, 1, 1, 1, 1, 0));
      else if (e < 209)  cyc($sformatf("to_wait_e%0d", e), ov(2'b10, 0, 1, 1, 1, 0));
`ifdef ATA_TIMEOUT_EN
      else               cyc("to_berr", ov(2'b10, 1, 1, 1, 0, 0));
`else
      else               cyc("to_noberr", ov(2'b10, 0, 1, 1, 1, 0));
`endif
    end
`ifdef ATA_TIMEOUT_EN
    cyc("to_berrw", ov(2'b10, 1, 1, 1, 0, 0));
    as20 = 1;
    cyc("to_hold", ov(2'b10, 1, 1, 1, 1, 1));
`else
    for (int i = 0; i < 5; i++) cyc("to_held", ov(2'b10, 0, 1, 1, 1, 0));
    idewait = 1;
    cyc("to_late_ack", ov(2'b10, 0, 1, 0, 1, 0));
    as20 = 1;
    cyc("to_hold", ov(2'b10, 1, 1, 1, 1, 1));
`endif
    idle_run("to_recover", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
